prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Launch controller between the bench/host req/ack handshake and the processor core.
- Each req rising edge launches the next program in round-robin order (program 0, 1, 2, 0, ...). It loads that program's start PC into the fetch unit, runs the core until halt, then raises ack.
- Measures the run length and enforces a watchdog so a hung program still returns ack.

Parameters:
PC_W, 10, width of the program counter / start address
START0, 10'd0, start PC of program 0
START1, 10'd128, start PC of program 1
START2, 10'd256, start PC of program 2
NUM_PROG, 3, number of programs in rotation (1..3)
CNT_W, 16, width of run-cycle counter
MAX_CYCLES, 16'd50000, watchdog limit in RUN cycles

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  1  start request from host; level, acted on at its rising edge
halt  input  1  core retired halt instruction (sampled in RUN only)
ack  output  1  program finished; high from completion until the next accepted req
pc_load  output  1  one-cycle pulse: fetch unit loads start_pc
start_pc  output  PC_W  start address of the current program
core_run  output  1  core enable; high only in RUN
prog_id  output  2  index of the current/last launched program
cycle_count  output  CNT_W  RUN cycles of the last completed program, saturating
timeout  output  1  last program ended by the watchdog, not by halt

Behaviour:
- Reset (async, reset=0):
  - Outputs: ack=0, pc_load=0, core_run=0, start_pc=START0, prog_id=0, cycle_count=0, timeout=0.
  - Internal: state=IDLE, req_q=0, next program index=0, watchdog counter=0.
  - Reset mid-RUN aborts the program immediately. There is no partial ack.
- Edge detect: req_q registers req; rise = req & ~req_q. A 1-cycle req pulse must be caught.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - All outputs at reset values.
  - On rise: latch prog_id = next index, start_pc = START[next], then go to LOAD.
- LOAD (exactly 1 cycle):
  - pc_load=1, core_run=0.
  - Clear the run counter and timeout.
  - Advance next index: wrap to 0 after NUM_PROG-1.
  - Go to RUN.
- RUN:
  - core_run=1. The counter increments every RUN cycle, saturating at 2^CNT_W-1.
  - halt=1 → DONE; cycle_count = counter value including the halt cycle.
  - Counter reaches MAX_CYCLES without halt → DONE with timeout=1; cycle_count=MAX_CYCLES.
  - If halt and the watchdog limit occur in the same cycle, halt wins and timeout=0.
- DONE:
  - ack=1, core_run=0; cycle_count and timeout hold.
  - On rise: ack=0 at that same edge, latch the next prog_id/start_pc, go to LOAD.
- ack timing: ack drops on the clock edge that samples req high, so a host that waits for ack after dropping req never sees a stale ack.
- Timing from req: req sampled high at edge N → pc_load high during cycle N..N+1 → core_run high from edge N+1.
- halt sampled at edge M → core_run low and ack high from edge M.
- req rises during LOAD or RUN: ignored and not queued. req held high through DONE does not retrigger; a new rising edge is required.
- halt outside RUN: ignored.
- prog_id/start_pc change only when a request is accepted, and hold through RUN and DONE.

Test Plan:
- Reset then launch: reset=0 for 2 cycles, release, 1-cycle req pulse → next cycle pc_load=1, start_pc=0, prog_id=0; following cycle core_run=1; ack=0 throughout.
- Halt timing: assert halt on the 5th RUN cycle → cycle_count=5, ack=1 and core_run=0 from that edge, timeout=0.
- Rotation/wrap: four successive req/halt rounds → start_pc 0, 128, 256, 0 and prog_id 0, 1, 2, 0; ack drops on each accepting edge.
- Watchdog: MAX_CYCLES=20, never assert halt → DONE after 20 RUN cycles, timeout=1, cycle_count=20, ack=1. Next launch clears timeout during LOAD.
- Ignored inputs:
  - req pulse mid-RUN → no effect; after halt, ack=1 and no second launch.
  - req held high across DONE entry → no relaunch until req falls and rises again.
  - halt pulse in IDLE/DONE → no state change.
- Reset mid-RUN: reset=0 at RUN cycle 3 → core_run=0, ack=0, prog_id=0 asynchronously. After release, req launches program 0 at start_pc=0.

Source files
------------

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : prog_sequencer
// Description : Launch controller between a host req/ack handshake and a
//               processor core. Each req rising edge launches the next program
//               in round-robin order: load its start PC, run the core until
//               halt (or until the watchdog expires), then raise ack.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START0     = 10'd0,
  parameter logic [PC_W-1:0] START1     = 10'd128,
  parameter logic [PC_W-1:0] START2     = 10'd256,
  parameter int              NUM_PROG   = 3,
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,       // asynchronous, active-low
  input  logic             req,
  input  logic             halt,
  output logic             ack,
  output logic             pc_load,
  output logic [PC_W-1:0]  start_pc,
  output logic             core_run,
  output logic [1:0]       prog_id,
  output logic [CNT_W-1:0] cycle_count,
  output logic             timeout
);

  // Controller states
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_LOAD = 2'd1;
  localparam logic [1:0] c_ST_RUN  = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_SAT   = '1;
  localparam logic [1:0]       c_LAST_PROG = 2'(NUM_PROG - 1);

  logic [1:0]       r_state;
  logic             r_req_q;
  logic [1:0]       r_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;
  logic             r_pc_load;
  logic [PC_W-1:0]  r_start_pc;
  logic             r_core_run;
  logic [1:0]       r_prog_id;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_timeout;

  logic             w_rise;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_wdog;
  logic [PC_W-1:0]  w_start_sel;
  logic [1:0]       w_next_adv;

  // A new request is only accepted while waiting (IDLE or DONE); rises seen
  // during LOAD/RUN are dropped, not queued.
  assign w_rise    = req & ~r_req_q;
  assign w_accept  = w_rise & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));

  // Run counter value including the current RUN cycle, saturating.
  assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_wdog    = (w_cnt_inc >= MAX_CYCLES);

  // Round-robin successor of the pending program index.
  assign w_next_adv = (r_next >= c_LAST_PROG) ? 2'd0 : r_next + 2'd1;

  // Start address of the program that would be launched next.
  always_comb begin
    w_start_sel = START0;
    case (r_next)
      2'd1:    w_start_sel = START1;
      2'd2:    w_start_sel = START2;
      default: w_start_sel = START0;
    endcase
  end

  // Sequencer state, request edge detector, run counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_req_q       <= 1'b0;
      r_next        <= 2'd0;
      r_cnt         <= '0;
      r_ack         <= 1'b0;
      r_pc_load     <= 1'b0;
      r_start_pc    <= START0;
      r_core_run    <= 1'b0;
      r_prog_id     <= 2'd0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_req_q   <= req;
      r_pc_load <= 1'b0;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (w_accept) begin
            // ack drops on the same edge that samples the new request
            r_ack      <= 1'b0;
            r_timeout  <= 1'b0;
            r_prog_id  <= r_next;
            r_start_pc <= w_start_sel;
            r_pc_load  <= 1'b1;
            r_state    <= c_ST_LOAD;
          end
        end
        c_ST_LOAD: begin
          r_cnt      <= '0;
          r_timeout  <= 1'b0;
          r_next     <= w_next_adv;
          r_core_run <= 1'b1;
          r_state    <= c_ST_RUN;
        end
        c_ST_RUN: begin
          r_cnt <= w_cnt_inc;
          // halt has priority over a watchdog expiry in the same cycle
          if (halt) begin
            r_cycle_count <= w_cnt_inc;
            r_timeout     <= 1'b0;
            r_core_run    <= 1'b0;
            r_ack         <= 1'b1;
            r_state       <= c_ST_DONE;
          end else if (w_wdog) begin
            r_cycle_count <= MAX_CYCLES;
            r_timeout     <= 1'b1;
            r_core_run    <= 1'b0;
            r_ack         <= 1'b1;
            r_state       <= c_ST_DONE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign pc_load     = r_pc_load;
  assign start_pc    = r_start_pc;
  assign core_run    = r_core_run;
  assign prog_id     = r_prog_id;
  assign cycle_count = r_cycle_count;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_sequencer
// Description : Self-checking bench for prog_sequencer. Directed scenarios and
//               random req/halt traffic are compared every cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;

  localparam int PC_W     = 10;
  localparam int CNT_W    = 16;
  localparam int NUM_PROG = 3;
  localparam int MAXC     = 20;
  localparam int START[3] = '{0, 128, 256};

  logic             clk;
  logic             reset;
  logic             req;
  logic             halt;
  logic             ack;
  logic             pc_load;
  logic [PC_W-1:0]  start_pc;
  logic             core_run;
  logic [1:0]       prog_id;
  logic [CNT_W-1:0] cycle_count;
  logic             timeout;

  prog_sequencer #(
    .PC_W(PC_W), .START0(10'd0), .START1(10'd128), .START2(10'd256),
    .NUM_PROG(NUM_PROG), .CNT_W(CNT_W), .MAX_CYCLES(16'd20)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .halt(halt), .ack(ack),
    .pc_load(pc_load), .start_pc(start_pc), .core_run(core_run),
    .prog_id(prog_id), .cycle_count(cycle_count), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a launch is a transaction remembered by the edge index
  // that accepted it; everything else follows from elapsed edges since then.
  int m_edge;        // running edge index
  int m_launch;      // edge that accepted the active launch
  bit m_busy;        // a launch is in flight (load or run)
  bit m_prev_req;
  int m_rr;          // next program in rotation
  int m_ack, m_pcl, m_run, m_pid, m_spc, m_cnt, m_to;

  task automatic model_reset();
    m_busy = 0; m_prev_req = 0; m_rr = 0;
    m_ack = 0; m_pcl = 0; m_run = 0; m_pid = 0; m_spc = START[0]; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_edge(input bit r, input bit h);
    bit rise;
    int elapsed;
    rise = r && !m_prev_req;
    m_prev_req = r;
    m_edge++;
    m_pcl = 0;
    if (!m_busy) begin
      if (rise) begin
        m_pid = m_rr; m_spc = START[m_rr]; m_rr = (m_rr + 1) % NUM_PROG;
        m_ack = 0; m_to = 0; m_pcl = 1; m_busy = 1; m_launch = m_edge;
      end
    end else if (m_edge == m_launch + 1) begin
      m_run = 1;
    end else begin
      elapsed = m_edge - m_launch - 1;   // RUN cycles completed, this one included
      if (h) begin
        m_cnt = elapsed; m_run = 0; m_ack = 1; m_busy = 0;
      end else if (elapsed >= MAXC) begin
        m_cnt = MAXC; m_to = 1; m_run = 0; m_ack = 1; m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("ack",         32'(ack),         m_ack);
    check("pc_load",     32'(pc_load),     m_pcl);
    check("core_run",    32'(core_run),    m_run);
    check("prog_id",     32'(prog_id),     m_pid);
    check("start_pc",    32'(start_pc),    m_spc);
    check("cycle_count", 32'(cycle_count), m_cnt);
    check("timeout",     32'(timeout),     m_to);
  endtask

  // One clock: drive inputs at the falling edge, advance the model at the
  // rising edge, compare just after it.
  task automatic step(input bit r, input bit h);
    @(negedge clk);
    req = r; halt = h;
    @(posedge clk);
    model_edge(r, h);
    #1;
    compare_all();
  endtask

  // Launch a program and halt it on RUN cycle n.
  task automatic run_prog(input int n);
    step(1, 0);
    step(0, 0);
    for (int i = 1; i < n; i++) step(0, 0);
    step(0, 1);
  endtask

  initial begin
    m_edge = 0;
    model_reset();
    req = 0; halt = 0; reset = 0;
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1;

    // First launch with a single-cycle req pulse, halt on the 5th RUN cycle
    step(1, 0);
    check("launch_pc_load", 32'(pc_load), 1);
    step(0, 0);
    check("launch_core_run", 32'(core_run), 1);
    for (int i = 0; i < 4; i++) step(0, 0);
    step(0, 1);
    check("halt5_count", 32'(cycle_count), 5);
    check("halt5_ack", 32'(ack), 1);
    step(0, 0);

    // Rotation through all programs and wrap
    for (int i = 0; i < 4; i++) begin
      run_prog(2 + i);
      step(0, 0);
    end

    // Watchdog: never halt
    step(1, 0);
    for (int i = 0; i < MAXC + 4; i++) step(0, 0);
    check("wdog_timeout", 32'(timeout), 1);
    check("wdog_count", 32'(cycle_count), MAXC);
    // Relaunch clears timeout
    step(1, 0);
    step(0, 0);
    check("wdog_cleared", 32'(timeout), 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    step(0, 1);

    // req pulse mid-RUN is ignored
    step(0, 0);
    step(1, 0); step(0, 0); step(0, 0);
    step(1, 0); step(0, 0); step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 0);

    // req held high across DONE entry must not relaunch
    step(1, 0); step(1, 0); step(1, 0); step(1, 1);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(0, 0);
    step(1, 0); step(0, 0); step(0, 1);

    // halt pulses in DONE are ignored
    step(0, 1); step(0, 0); step(0, 1);

    // Asynchronous reset during RUN cycle 3
    step(1, 0); step(0, 0); step(0, 0); step(0, 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1;
    // halt in IDLE ignored, then program 0 launches again
    step(0, 1); step(0, 0);
    run_prog(3);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 6) == 0, ($urandom % 9) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
